// File: rtl/x_count_4_bit_monitor_pkg.sv
// ----------------------------------------------------------------------------
// x_count_4_bit_monitor_pkg
// Shared constants and the monitor state type for the 4-bit counter monitor.
// ----------------------------------------------------------------------------
package x_count_4_bit_monitor_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam logic [3:0]  ERR_MAX = 4'd15;

    typedef enum logic [1:0] {
        MON_IDLE   = 2'd0,
        MON_ACQ    = 2'd1,
        MON_LOCKED = 2'd2
    } mon_state_t;

endpackage

// File: rtl/x_sat_counter_4_bit.sv
// ----------------------------------------------------------------------------
// x_sat_counter_4_bit
// 4-bit up counter that stops at ERR_MAX and holds there.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset, clears the count
//   i_inc   - increment request for this cycle
//   o_count - registered count value
// ----------------------------------------------------------------------------
module x_sat_counter_4_bit
    import x_count_4_bit_monitor_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != ERR_MAX)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/x_count_4_bit_monitor.sv
// ----------------------------------------------------------------------------
// x_count_4_bit_monitor
// Checks that the observed 4-bit count advances by exactly one (mod 16) every
// clock. Declares lock after LOCK_N consecutive good increments, pulses an
// error on loss of lock, pulses wrap on a 15->0 step while locked, and keeps
// a saturating tally of lock losses.
// Ports:
//   i_clk                          - clock, rising edge
//   i_rst                          - asynchronous active-high reset
//   i_count_3 .. i_count_0         - observed count, MSB..LSB
//   o_locked                       - high while locked
//   o_error                        - one-cycle pulse on loss of lock
//   o_wrap                         - one-cycle pulse on 15->0 while locked
//   o_err_count_3 .. o_err_count_0 - saturating loss count, MSB..LSB
// ----------------------------------------------------------------------------
module x_count_4_bit_monitor
    import x_count_4_bit_monitor_pkg::*;
#(
    parameter int unsigned LOCK_N = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_count_3,
    input  logic i_count_2,
    input  logic i_count_1,
    input  logic i_count_0,
    output logic o_locked,
    output logic o_error,
    output logic o_wrap,
    output logic o_err_count_3,
    output logic o_err_count_2,
    output logic o_err_count_1,
    output logic o_err_count_0
);

    localparam int unsigned      RUN_W    = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_N - 1);

    logic [CNT_W-1:0] r_prev;
    logic [RUN_W-1:0] r_run;
    mon_state_t       r_state;
    logic             r_error;
    logic             r_wrap;

    logic [CNT_W-1:0] w_cur;
    logic             w_good;
    logic             w_wrap_step;
    logic             w_loss;
    logic [RUN_W-1:0] w_run_next;
    mon_state_t       w_state_next;
    logic [CNT_W-1:0] w_err_count;

    assign w_cur       = {i_count_3, i_count_2, i_count_1, i_count_0};
    // 4-bit compare, so 15 followed by 0 counts as good.
    assign w_good      = (w_cur == r_prev + 4'd1);
    assign w_wrap_step = (r_prev == 4'hF) && (w_cur == 4'h0);
    assign w_loss      = (r_state == MON_LOCKED) && !w_good;

    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        unique case (r_state)
            MON_IDLE: begin
                // Capture edge only; nothing to compare against yet.
                w_state_next = MON_ACQ;
                w_run_next   = '0;
            end
            MON_ACQ: begin
                if (w_good && (r_run == RUN_LAST)) begin
                    w_state_next = MON_LOCKED;
                    w_run_next   = '0;
                end else if (w_good) begin
                    w_run_next = r_run + 1'b1;
                end else begin
                    w_run_next = '0;
                end
            end
            MON_LOCKED: begin
                if (!w_good) begin
                    w_state_next = MON_ACQ;
                    w_run_next   = '0;
                end
            end
            default: begin
                w_state_next = MON_IDLE;
                w_run_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= '0;
            r_run   <= '0;
            r_state <= MON_IDLE;
            r_error <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_prev  <= w_cur;
            r_run   <= w_run_next;
            r_state <= w_state_next;
            r_error <= w_loss;
            r_wrap  <= (r_state == MON_LOCKED) && w_good && w_wrap_step;
        end
    end

    x_sat_counter_4_bit u_err_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_loss),
        .o_count (w_err_count)
    );

    assign o_locked      = (r_state == MON_LOCKED);
    assign o_error       = r_error;
    assign o_wrap        = r_wrap;
    assign o_err_count_3 = w_err_count[3];
    assign o_err_count_2 = w_err_count[2];
    assign o_err_count_1 = w_err_count[1];
    assign o_err_count_0 = w_err_count[0];

endmodule

// File: doc/x_count_4_bit_monitor.md
# x_count_4_bit_monitor

Receive-side checker for the four bit-level outputs of the 4-bit free-running counter. It samples the count bits every clock and checks that each value is the previous value plus one (mod 16). It reports lock, per-event error and wrap pulses, and a saturating error tally. It sits on the board-level side of the counter, clocked by the same clock, and provides a visible health indication for the counter chain.

## Interface
- `LOCK_N`, default 4: consecutive good increments required to declare lock; legal range 1..15.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_count_3` .. `i_count_0` in 1 each: observed count, MSB..LSB; synchronous to `i_clk`.
- `o_locked` out 1: registered; high while the monitor is in LOCKED.
- `o_error` out 1: registered one-cycle pulse on loss of lock.
- `o_wrap` out 1: registered one-cycle pulse on a 15->0 transition seen while LOCKED.
- `o_err_count_3` .. `o_err_count_0` out 1 each: registered, saturating count of lock losses, MSB..LSB.

## Operation
- Registers:
  - `prev_q[3:0]`: last sample.
  - `run_q`: $clog2(LOCK_N+1) bits.
  - `state_q`: IDLE, ACQ or LOCKED.
  - `err_q[3:0]`.
  - The `o_error` and `o_wrap` flops.
- `cur = {i_count_3..i_count_0}`.
- `good = (cur == prev_q + 4'd1)`, computed in 4 bits, so `prev_q=15, cur=0` is good.
- `prev_q <= cur` on every clock out of reset, in all states.
- IDLE (reset state):
  - Next edge: capture `cur`, go to ACQ with `run_q=0`.
  - No check is performed in IDLE.
- ACQ:
  - If good and `run_q == LOCK_N-1`: go to LOCKED, `run_q` cleared.
  - Else if good: `run_q++`.
  - Else: `run_q=0` and stay in ACQ.
  - No `o_error` is generated and `err_q` is unchanged while in ACQ.
- LOCKED:
  - good: stay. If additionally `prev_q==15` and `cur==0`, pulse `o_wrap`.
  - not good: go to ACQ with `run_q=0`, pulse `o_error`, and set `err_q = min(err_q+1, 15)`.
- Stuck input (`cur == prev_q`) counts as not good.
- A mismatch that is itself `prev+1` of the bad value resumes acquisition from a run of 1 on the following compare.

## Timing
- Reset values: `o_locked=0`, `o_error=0`, `o_wrap=0`, `o_err_count_*=0`. Internally `prev_q=0`, `run_q=0`, state IDLE.
- Assertion of `i_rst` takes effect immediately, with no clock needed, including mid-lock. Deassertion is used synchronously at the next edge.
- Compare latency: `cur` present before edge N is compared at edge N. `o_error`/`o_wrap` are high for exactly the cycle after edge N. `o_locked` and `o_err_count_*` update at edge N.
- Lock latency from reset release, with a correct counter: 1 capture edge plus `LOCK_N` good edges. For `LOCK_N=4`, `o_locked` rises after the 5th edge.
- Loss of lock:
  - `o_locked` falls at the same edge that raises `o_error`.
  - Relock then needs `LOCK_N` further good edges.
- `o_error` and `o_wrap` are mutually exclusive in any cycle.
- Error tally saturates at 15 and holds. Further losses still pulse `o_error`.

## Structure
- Package `x_count_4_bit_monitor_pkg` contains:
  - `CNT_W = 4`.
  - `ERR_MAX = 4'd15`.
  - The state enum `mon_state_t {MON_IDLE, MON_ACQ, MON_LOCKED}`, 2 bits.
- One sub-module, `x_sat_counter_4_bit`:
  - Ports: clock, async active-high reset, increment enable.
  - 4-bit saturating counter, used for `err_q`.
- Top level contains the sample register, the compare logic, the FSM and the pulse flops.

## Test plan
- Reset then a correct counter sequence 0,1,2,... with `LOCK_N=4` -> `o_locked` low through the first 4 edges after release and high after the 5th; `o_error` never asserted.
- Locked, drive 15 then 0 -> `o_wrap` high for exactly one cycle; `o_locked` stays high; `err_count=0`.
- Locked at value 6, inject 9 -> one-cycle `o_error`, `o_locked` falls, `err_count=1`. Continue 10,11,12,13 -> relock after the 4th good edge.
- Stuck input (5,5,5...) in ACQ -> never locks, no `o_error`, `err_count` unchanged. In LOCKED, one repeat -> one `o_error`.
- Force 17 lock-loss events -> `err_count` saturates at 15 and `o_error` pulses all 17 times.
- Assert `i_rst` asynchronously mid-LOCKED between edges -> all outputs 0 immediately. After release, IDLE re-acquisition matches the first scenario.
